// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the multi-word ALU sequencer: FSM states,
// opcode encodings of the attached ALU, wide-width helper and opcode classifiers.
package alu_seq_pkg;

    localparam int OP_RCA      = 0;
    localparam int OP_RCS      = 1;
    localparam int OP_AND      = 2;
    localparam int OP_OR       = 3;
    localparam int OP_XOR      = 4;
    localparam int OP_SHIFT_LS = 5;
    localparam int OP_SHIFT_LD = 6;
    localparam int OP_SHIFT_AS = 7;
    localparam int OP_SHIFT_AD = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic int wide_width(input int n, input int words);
        return n * words;
    endfunction

    function automatic logic is_known_op(input logic [31:0] op);
        return op <= 32'(OP_SHIFT_AD);
    endfunction

    function automatic logic is_arith_op(input logic [31:0] op);
        return (op == 32'(OP_RCA)) || (op == 32'(OP_RCS));
    endfunction

endpackage

// File: rtl/alu_seq_patch.sv
// Boundary-bit fixup of one ALU result word so word-wise shifts behave as one wide shift.
// Purely combinational; no handshake.
module alu_seq_patch
    import alu_seq_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic [M-1:0] op,
    input  logic         first_word,
    input  logic         last_word,
    input  logic [N-1:0] alu_word,
    input  logic         prev_msb,
    input  logic         next_lsb,
    output logic [N-1:0] word
);

    logic shl;
    logic shr;

    assign shl = (op == M'(OP_SHIFT_LS)) || (op == M'(OP_SHIFT_AS));
    assign shr = (op == M'(OP_SHIFT_LD)) || (op == M'(OP_SHIFT_AD));

    // The top word of an arithmetic right shift keeps the ALU's sign fill.
    always_comb begin
        word = alu_word;
        if (shl && !first_word) begin
            word[0] = prev_msb;
        end
        if (shr && !last_word) begin
            word[N-1] = next_lsb;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Walks WORDS-word operands through an N-bit combinational ALU, LS word first; rsp_valid WORDS cycles after accept.
// Response held until rsp_ready; requests taken only in IDLE, or also in DONE with rsp_ready when ALU_SEQ_PIPE_EN is defined.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int N     = 32,
    parameter int WORDS = 2,
    parameter int M     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [M-1:0]         req_op,
    input  logic [N*WORDS-1:0]   req_a,
    input  logic [N*WORDS-1:0]   req_b,
    input  logic                 req_cin,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [M-1:0]         alu_sel,
    output logic                 alu_cin,
    input  logic [N-1:0]         alu_res,
    input  logic                 alu_cout,
    input  logic                 alu_neg,
    input  logic                 alu_ovf,
    input  logic                 alu_null,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N*WORDS-1:0]   rsp_res,
    output logic                 rsp_cout,
    output logic                 rsp_neg,
    output logic                 rsp_ovf,
    output logic                 rsp_null
);

    localparam int W     = wide_width(N, WORDS);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t state_q, state_d;

    logic [WORDS-1:0][N-1:0] a_q, b_q, res_q, res_next;
    logic [IDX_W-1:0]        idx_q, next_idx, prev_idx;
    logic                    accept, step, finish, release_rsp;
    logic                    first_word, last_word, known_op, arith_op;
    logic [N-1:0]            patched_word;
    logic                    unused_alu_flags;

    // Result flags are rebuilt over the full wide word, so the per-word ones are not needed.
    assign unused_alu_flags = alu_neg ^ alu_null;

    assign first_word = (idx_q == '0);
    assign last_word  = (idx_q == LAST_IDX);
    assign next_idx   = last_word  ? idx_q : idx_q + IDX_W'(1);
    assign prev_idx   = first_word ? idx_q : idx_q - IDX_W'(1);
    assign known_op   = is_known_op(32'(alu_sel));
    assign arith_op   = is_arith_op(32'(alu_sel));

    alu_seq_patch #(
        .N (N),
        .M (M)
    ) u_patch (
        .op         (alu_sel),
        .first_word (first_word),
        .last_word  (last_word),
        .alu_word   (alu_res),
        .prev_msb   (a_q[prev_idx][N-1]),
        .next_lsb   (a_q[next_idx][0]),
        .word       (patched_word)
    );

    always_comb begin
        res_next         = res_q;
        res_next[idx_q]  = patched_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        release_rsp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (last_word) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_d     = ST_IDLE;
                end
`ifdef ALU_SEQ_PIPE_EN
                if (rsp_ready && !rst) begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept  = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            alu_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_cout  <= 1'b0;
            rsp_neg   <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_null  <= 1'b0;
        end else begin
            if (release_rsp) begin
                rsp_valid <= 1'b0;
            end
            if (accept) begin
                a_q     <= req_a;
                b_q     <= req_b;
                idx_q   <= '0;
                alu_a   <= req_a[N-1:0];
                alu_b   <= req_b[N-1:0];
                alu_sel <= req_op;
                alu_cin <= req_cin;
            end
            if (step || finish) begin
                res_q <= res_next;
            end
            // alu_cin doubles as the inter-word carry register.
            if (step) begin
                idx_q   <= next_idx;
                alu_a   <= a_q[next_idx];
                alu_b   <= b_q[next_idx];
                alu_cin <= arith_op ? alu_cout : 1'b0;
            end
            if (finish) begin
                rsp_valid <= 1'b1;
                rsp_res   <= known_op ? W'(res_next) : '0;
                rsp_cout  <= known_op && arith_op && alu_cout;
                rsp_ovf   <= known_op && arith_op && alu_ovf;
                rsp_neg   <= known_op && res_next[WORDS-1][N-1];
                rsp_null  <= known_op ? (res_next == '0) : 1'b1;
            end
        end
    end

endmodule
